mult_pow2_pipe: RTL and testbench

Parametrised pipelined power-of-two multiplier, successor to the fixed 10-bit registered ×2 block. It multiplies an unsigned WIDTH-bit operand by 2^shamt, where shamt is chosen per transaction. It supports wrap or saturate overflow handling, and a valid/ready handshake with backpressure. A saturating overflow-event counter is included. It sits in the arithmetic datapath between operand staging and downstream accumulate logic.

---
 rtl/mult_pkg.sv | 15 +
 rtl/mult_pow2_pipe_if.sv | 30 +++
 rtl/mult_pow2_pipe_stage.sv | 22 ++
 rtl/mult_pow2_pipe.sv | 93 +++++++++
 tb/tb_mult_pow2_pipe.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the power-of-two multiplier pipeline.
// Holds the overflow-mode encodings and the full-product width helper.
// The per-stage payload struct depends on WIDTH, so each instantiating module declares it.
package mult_pkg;

  // Values of sat_en
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Width of {operand, shamt zeros} at the largest shift: WIDTH + 2^SHW - 1
  function automatic int full_width(input int width, input int shw);
    return width + (1 << shw) - 1;
  endfunction

endpackage

// File: rtl/mult_pow2_pipe_if.sv
// Handshake bundle for mult_pow2_pipe: operand side, result side and counter access.
// master = upstream/downstream environment, slave = the multiplier block.
// Ports: in/shamt/sat_en/in_valid/in_ready, out/out_ovf/out_valid/out_ready, ovf_cnt/cnt_clr.
interface mult_pow2_pipe_if #(
  parameter int WIDTH     = 10,
  parameter int SHW       = 3,
  parameter int CNT_WIDTH = 16
);
  logic [WIDTH-1:0]     in;
  logic [SHW-1:0]       shamt;
  logic                 sat_en;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     out;
  logic                 out_ovf;
  logic                 out_valid;
  logic                 out_ready;
  logic [CNT_WIDTH-1:0] ovf_cnt;
  logic                 cnt_clr;

  modport master (
    output in, shamt, sat_en, in_valid, out_ready, cnt_clr,
    input  in_ready, out, out_ovf, out_valid, ovf_cnt
  );

  modport slave (
    input  in, shamt, sat_en, in_valid, out_ready, cnt_clr,
    output in_ready, out, out_ovf, out_valid, ovf_cnt
  );
endinterface

// File: rtl/mult_pow2_pipe_stage.sv
// One pipeline register of the multiplier: loads d when en is high, otherwise holds.
// Latency: 1 cycle. Backpressure: en low freezes the stage contents.
// Ports: clk, rst_n (async, active-low, clears to zero), en, d (payload in), q (payload out).
module mult_pow2_stage #(
  parameter type payload_t = logic
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  input  payload_t d,
  output payload_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mult_pow2_pipe.sv
// Pipelined multiply by 2^shamt with wrap/saturate overflow and a saturating overflow counter.
// Latency: STAGES cycles, 1 transaction/cycle. Backpressure: global stall, all stages hold while
// out_valid & !out_ready; in_ready = !stall. Ports: clk, rst_n, bus (mult_pow2_pipe_if.slave).
module mult_pow2_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int SHW       = 3,
  parameter int STAGES    = 2,
  parameter int CNT_WIDTH = 16
) (
  input logic            clk,
  input logic            rst_n,
  mult_pow2_pipe_if.slave bus
);

  localparam int FULL_W = full_width(WIDTH, SHW);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] result;
    logic             ovf;
  } stage_t;

  logic [FULL_W-1:0]    full;
  logic                 ovf;
  logic [WIDTH-1:0]     result;
  stage_t               in_stage;
  stage_t               pipe_d [STAGES];
  stage_t               pipe_q [STAGES];
  stage_t               last;
  logic                 stall;
  logic                 out_xfer;
  logic [CNT_WIDTH-1:0] cnt_q;

  // Shift into a register wide enough for the largest shift so no product bit is lost.
  always_comb begin
    full   = FULL_W'(bus.in) << bus.shamt;
    ovf    = |full[FULL_W-1:WIDTH];
    result = ((bus.sat_en == MODE_SAT) && ovf) ? '1 : full[WIDTH-1:0];
  end

  // Invalid slots carry zero data so bubbles read cleanly on waveforms.
  always_comb begin
    in_stage = '0;
    if (bus.in_valid) begin
      in_stage.valid  = 1'b1;
      in_stage.result = result;
      in_stage.ovf    = ovf;
    end
  end

  always_comb begin
    pipe_d[0] = in_stage;
    for (int i = 1; i < STAGES; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  assign last  = pipe_q[STAGES-1];
  // Bubbles are not squeezed out: a valid head stalls the whole pipe.
  assign stall = last.valid & ~bus.out_ready;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    mult_pow2_stage #(.payload_t(stage_t)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (~stall),
      .d     (pipe_d[g]),
      .q     (pipe_q[g])
    );
  end

  assign out_xfer = last.valid & bus.out_ready;

  // Clear wins over a same-cycle overflow delivery; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if (out_xfer && last.ovf && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.in_ready  = ~stall;
  assign bus.out       = last.result;
  assign bus.out_ovf   = last.ovf;
  assign bus.out_valid = last.valid;
  assign bus.ovf_cnt   = cnt_q;

endmodule

// File: tb/tb_mult_pow2_pipe.sv
// Directed bench for mult_pow2_pipe: four builds (STAGES 2/2/1/4, CNT_WIDTH 16/4/16/16)
// share one stimulus stream; results are captured per build and compared to a vector table.
// Hand-written sequences cover backpressure, counter saturation/clear and mid-stream reset.
module tb_mult_pow2_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] in_d;
  logic [2:0] shamt_d;
  logic       sat_d, vld_d, ordy_d, clr_d;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_pow2_pipe_if #(.WIDTH(10), .SHW(3), .CNT_WIDTH(16)) if0 ();
  mult_pow2_pipe_if #(.WIDTH(10), .SHW(3), .CNT_WIDTH(4))  if1 ();
  mult_pow2_pipe_if #(.WIDTH(10), .SHW(3), .CNT_WIDTH(16)) if2 ();
  mult_pow2_pipe_if #(.WIDTH(10), .SHW(3), .CNT_WIDTH(16)) if3 ();

  assign if0.in = in_d; assign if0.shamt = shamt_d; assign if0.sat_en = sat_d;
  assign if0.in_valid = vld_d; assign if0.out_ready = ordy_d; assign if0.cnt_clr = clr_d;
  assign if1.in = in_d; assign if1.shamt = shamt_d; assign if1.sat_en = sat_d;
  assign if1.in_valid = vld_d; assign if1.out_ready = ordy_d; assign if1.cnt_clr = clr_d;
  assign if2.in = in_d; assign if2.shamt = shamt_d; assign if2.sat_en = sat_d;
  assign if2.in_valid = vld_d; assign if2.out_ready = ordy_d; assign if2.cnt_clr = clr_d;
  assign if3.in = in_d; assign if3.shamt = shamt_d; assign if3.sat_en = sat_d;
  assign if3.in_valid = vld_d; assign if3.out_ready = ordy_d; assign if3.cnt_clr = clr_d;

  mult_pow2_pipe #(.WIDTH(10), .SHW(3), .STAGES(2), .CNT_WIDTH(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  mult_pow2_pipe #(.WIDTH(10), .SHW(3), .STAGES(2), .CNT_WIDTH(4))  dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  mult_pow2_pipe #(.WIDTH(10), .SHW(3), .STAGES(1), .CNT_WIDTH(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  mult_pow2_pipe #(.WIDTH(10), .SHW(3), .STAGES(4), .CNT_WIDTH(16)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  typedef struct {
    int         cyc;
    logic       ovf;
    logic [9:0] dat;
  } cap_t;

  cap_t capq[4][$];

  // Outputs that transfer at the next rising edge, observed half a cycle earlier.
  always @(negedge clk) if (if0.out_valid && ordy_d) capq[0].push_back('{cyc, if0.out_ovf, if0.out});
  always @(negedge clk) if (if1.out_valid && ordy_d) capq[1].push_back('{cyc, if1.out_ovf, if1.out});
  always @(negedge clk) if (if2.out_valid && ordy_d) capq[2].push_back('{cyc, if2.out_ovf, if2.out});
  always @(negedge clk) if (if3.out_valid && ordy_d) capq[3].push_back('{cyc, if3.out_ovf, if3.out});

  typedef struct {
    logic [9:0] a;
    logic [2:0] s;
    logic       sat;
    logic [9:0] e_out;
    logic       e_ovf;
  } vec_t;

  vec_t vt[12];
  int   acc[12];
  int   stages_of[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the operand.
  task automatic send(input logic [9:0] a, input logic [2:0] s, input logic st, output int acc_cyc);
    bit ok;
    ok      = 1'b0;
    acc_cyc = -1;
    in_d    = a;
    shamt_d = s;
    sat_d   = st;
    vld_d   = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (if0.in_ready) begin
        ok      = 1'b1;
        acc_cyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    vld_d = 1'b0;
  endtask

  initial begin
    int a_tmp;
    int k;

    stages_of = '{2, 2, 1, 4};
    vt[0]  = '{10'd1,    3'd1, 1'b0, 10'd2,    1'b0};
    vt[1]  = '{10'd10,   3'd1, 1'b0, 10'd20,   1'b0};
    vt[2]  = '{10'd21,   3'd1, 1'b0, 10'd42,   1'b0};
    vt[3]  = '{10'd42,   3'd1, 1'b0, 10'd84,   1'b0};
    vt[4]  = '{10'd400,  3'd1, 1'b0, 10'd800,  1'b0};
    vt[5]  = '{10'd987,  3'd1, 1'b0, 10'd950,  1'b1};
    vt[6]  = '{10'd987,  3'd1, 1'b1, 10'd1023, 1'b1};
    vt[7]  = '{10'd1,    3'd7, 1'b0, 10'd128,  1'b0};
    vt[8]  = '{10'd1023, 3'd0, 1'b1, 10'd1023, 1'b0};
    vt[9]  = '{10'd512,  3'd7, 1'b0, 10'd0,    1'b1};
    vt[10] = '{10'd3,    3'd7, 1'b1, 10'd384,  1'b0};
    vt[11] = '{10'd8,    3'd7, 1'b1, 10'd1023, 1'b1};

    rst_n = 1'b0; in_d = '0; shamt_d = '0; sat_d = 1'b0;
    vld_d = 1'b0; ordy_d = 1'b1; clr_d = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", 32'(if0.out), 0);
    chk("rst_out_ovf", 32'(if0.out_ovf), 0);
    chk("rst_out_valid", 32'(if0.out_valid), 0);
    chk("rst_ovf_cnt", 32'(if0.ovf_cnt), 0);
    chk("rst_in_ready", 32'(if0.in_ready), 1);
    chk("rst_s4_out_valid", 32'(if3.out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table sweep, back-to-back, out_ready high: data, overflow flag and latency per build
    for (int i = 0; i < 12; i++) send(vt[i].a, vt[i].s, vt[i].sat, acc[i]);
    repeat (8) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("d%0d_count", d), 32'(capq[d].size()), 12);
      for (int i = 0; i < 12; i++) begin
        if (i < capq[d].size()) begin
          chk($sformatf("d%0d_v%0d_out", d, i), 32'(capq[d][i].dat), 32'(vt[i].e_out));
          chk($sformatf("d%0d_v%0d_ovf", d, i), 32'(capq[d][i].ovf), 32'(vt[i].e_ovf));
          chk($sformatf("d%0d_v%0d_latency", d, i), 32'(capq[d][i].cyc - acc[i]), 32'(stages_of[d]));
        end
      end
    end
    chk("sweep_cnt0", 32'(if0.ovf_cnt), 4);
    chk("sweep_cnt1", 32'(if1.ovf_cnt), 4);
    chk("sweep_cnt2", 32'(if2.ovf_cnt), 4);
    chk("sweep_cnt3", 32'(if3.ovf_cnt), 4);

    // Backpressure: out_ready low for 3 cycles once the first result is presented
    capq[0].delete();
    fork
      begin
        send(10'd5,   3'd1, 1'b0, a_tmp);
        send(10'd6,   3'd2, 1'b0, a_tmp);
        send(10'd7,   3'd3, 1'b0, a_tmp);
        send(10'd100, 3'd3, 1'b0, a_tmp);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        ordy_d = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready_low", 32'(if0.in_ready), 0);
          chk("bp_out_valid_held", 32'(if0.out_valid), 1);
          chk("bp_out_held", 32'(if0.out), 10);
        end
        @(posedge clk);
        #1;
        ordy_d = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    chk("bp_count", 32'(capq[0].size()), 4);
    if (capq[0].size() == 4) begin
      chk("bp_out0", 32'(capq[0][0].dat), 10);
      chk("bp_out1", 32'(capq[0][1].dat), 24);
      chk("bp_out2", 32'(capq[0][2].dat), 56);
      chk("bp_out3", 32'(capq[0][3].dat), 800);
    end

    // Counter saturation (4-bit build) and clear priority
    clr_d = 1'b1;
    @(posedge clk);
    #1;
    clr_d = 1'b0;
    chk("clr_cnt1", 32'(if1.ovf_cnt), 0);
    chk("clr_cnt0", 32'(if0.ovf_cnt), 0);
    for (int i = 0; i < 17; i++) send(10'd987, 3'd1, 1'b0, a_tmp);
    repeat (8) @(posedge clk);
    #1;
    chk("sat_cnt1_stuck", 32'(if1.ovf_cnt), 15);
    chk("sat_cnt0_free", 32'(if0.ovf_cnt), 17);
    send(10'd987, 3'd1, 1'b0, a_tmp);
    k = 0;
    while (k < 10) begin
      @(negedge clk);
      if (if1.out_valid) break;
      k++;
    end
    chk("clrpri_wait_valid", 32'(if1.out_valid), 1);
    clr_d = 1'b1;
    @(posedge clk);
    #1;
    clr_d = 1'b0;
    chk("clrpri_cnt1", 32'(if1.ovf_cnt), 0);
    chk("clrpri_cnt0", 32'(if0.ovf_cnt), 0);
    chk("clrpri_delivered", 32'(if1.out_valid), 0);
    @(posedge clk);
    #1;
    chk("clrpri_cnt1_later", 32'(if1.ovf_cnt), 0);

    // Asynchronous reset between edges with two transactions in flight
    send(10'd5, 3'd1, 1'b0, a_tmp);
    send(10'd6, 3'd1, 1'b0, a_tmp);
    chk("rstm_pre_valid", 32'(if0.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstm_out_valid", 32'(if0.out_valid), 0);
    chk("rstm_out", 32'(if0.out), 0);
    chk("rstm_out_ovf", 32'(if0.out_ovf), 0);
    chk("rstm_s4_valid", 32'(if3.out_valid), 0);
    chk("rstm_in_ready", 32'(if0.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    capq[0].delete();
    repeat (4) @(posedge clk);
    #1;
    chk("rstm_no_stale", 32'(capq[0].size()), 0);
    send(10'd7, 3'd2, 1'b0, a_tmp);
    repeat (4) @(posedge clk);
    #1;
    chk("rstm_next_count", 32'(capq[0].size()), 1);
    if (capq[0].size() == 1) begin
      chk("rstm_next_out", 32'(capq[0][0].dat), 28);
      chk("rstm_next_latency", 32'(capq[0][0].cyc - a_tmp), 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
